// File: rtl/mpram_pkg.sv
// Shared definitions for the multi-port RAM: FSM state encoding and default geometry.
package mpram_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DEPTH  = 1024;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

endpackage

// File: rtl/mpram_if.sv
// Port bundle of the multi-port RAM; master drives requests, slave (the RAM) answers.
interface mpram_if
    import mpram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NR     = 4,
    parameter int NW     = 2
) ();

    logic                 clr;
    logic                 ready;
    logic [NW-1:0]        wr_en;
    logic [NW*ADDR_W-1:0] wr_addr;
    logic [NW*DATA_W-1:0] wr_data;
    logic [NR-1:0]        rd_en;
    logic [NR*ADDR_W-1:0] rd_addr;
    logic [NR*DATA_W-1:0] rd_data;
    logic [NR-1:0]        rd_valid;
    logic                 wr_conflict;

    modport master (
        output clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  ready, rd_data, rd_valid, wr_conflict
    );

    modport slave (
        input  clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output ready, rd_data, rd_valid, wr_conflict
    );

endinterface

// File: rtl/mpram_bank.sv
// One full copy of the array: NW write ports, one registered read port and
// optional write-to-read forwarding for same-cycle same-address accesses.
module mpram_bank
    import mpram_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NW       = 2,
    parameter int RDW_MODE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NW-1:0]        we,
    input  logic [NW*ADDR_W-1:0] waddr,
    input  logic [NW*DATA_W-1:0] wdata,
    input  logic                 clr_en,
    input  logic [ADDR_W-1:0]    clr_addr,
    input  logic                 re,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [DATA_W-1:0]    rdata,
    output logic                 rvalid
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [0:DEPTH-1];
    logic [DATA_W-1:0] rdata_r;
    logic              rvalid_r;
    logic              fwd_hit_s;
    logic [DATA_W-1:0] fwd_data_s;
    logic [DATA_W-1:0] rd_word_s;

    // Storage update: the sweep owns the array while clearing; enables are pre-arbitrated.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem_r[clr_addr] <= '0;
        end else begin
            for (int p = 0; p < NW; p++) begin
                if (we[p]) begin
                    mem_r[waddr[p*ADDR_W +: ADDR_W]] <= wdata[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Forwarding select: at most one enabled write can match, losers are already masked.
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = '0;
        for (int p = 0; p < NW; p++) begin
            fwd_hit_s  = fwd_hit_s | (we[p] & (waddr[p*ADDR_W +: ADDR_W] == raddr));
            fwd_data_s = (we[p] && (waddr[p*ADDR_W +: ADDR_W] == raddr))
                         ? wdata[p*DATA_W +: DATA_W] : fwd_data_s;
        end
        if ((RDW_MODE != 0) && fwd_hit_s) begin
            rd_word_s = fwd_data_s;
        end else begin
            rd_word_s = mem_r[raddr];
        end
    end

    // Read register: data holds its last value when no read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r  <= '0;
            rvalid_r <= 1'b0;
        end else begin
            rvalid_r <= re;
            if (re) begin
                rdata_r <= rd_word_s;
            end
        end
    end

    assign rdata  = rdata_r;
    assign rvalid = rvalid_r;

endmodule

// File: rtl/mpram.sv
// Multi-port RAM top: clear sweep FSM, write masking and same-address arbitration,
// feeding NR replicated banks so every read port observes every write.
module mpram
    import mpram_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NR       = 4,
    parameter int NW       = 2,
    parameter int RDW_MODE = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    mpram_if.slave bus
);

    state_t              state_r;
    logic [ADDR_W-1:0]   cnt_r;
    logic                ready_r;
    logic                wr_conflict_r;
    logic                active_s;
    logic                clearing_s;
    logic [NW-1:0]       wr_win_s;
    logic                conflict_s;
    logic [NR-1:0]       rd_en_s;
    logic [NR*DATA_W-1:0] rd_data_s;
    logic [NR-1:0]       rd_valid_s;

    assign active_s   = (state_r == ST_READY);
    assign clearing_s = (state_r == ST_CLEAR);
    assign rd_en_s    = active_s ? bus.rd_en : '0;

    // Arbitration: a port loses to any higher-index enabled port on the same address.
    always_comb begin
        conflict_s = 1'b0;
        for (int p = 0; p < NW; p++) begin
            wr_win_s[p] = active_s & bus.wr_en[p];
            for (int q = p + 1; q < NW; q++) begin
                wr_win_s[p] = wr_win_s[p] & ~(bus.wr_en[q] &
                              (bus.wr_addr[p*ADDR_W +: ADDR_W] == bus.wr_addr[q*ADDR_W +: ADDR_W]));
                conflict_s  = conflict_s | (active_s & bus.wr_en[p] & bus.wr_en[q] &
                              (bus.wr_addr[p*ADDR_W +: ADDR_W] == bus.wr_addr[q*ADDR_W +: ADDR_W]));
            end
        end
    end

    // Control FSM with sweep counter; ready flips on the edge that writes the last address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_CLEAR;
            cnt_r         <= '0;
            ready_r       <= 1'b0;
            wr_conflict_r <= 1'b0;
        end else begin
            wr_conflict_r <= conflict_s;
            case (state_r)
                ST_CLEAR: begin
                    cnt_r <= cnt_r + ADDR_W'(1);
                    if (cnt_r == '1) begin
                        state_r <= ST_READY;
                        ready_r <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (bus.clr) begin
                        state_r <= ST_CLEAR;
                        cnt_r   <= '0;
                        ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_CLEAR;
                    cnt_r   <= '0;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    for (genvar j = 0; j < NR; j++) begin : g_bank
        mpram_bank #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NW       (NW),
            .RDW_MODE (RDW_MODE)
        ) u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .we       (wr_win_s),
            .waddr    (bus.wr_addr),
            .wdata    (bus.wr_data),
            .clr_en   (clearing_s),
            .clr_addr (cnt_r),
            .re       (rd_en_s[j]),
            .raddr    (bus.rd_addr[j*ADDR_W +: ADDR_W]),
            .rdata    (rd_data_s[j*DATA_W +: DATA_W]),
            .rvalid   (rd_valid_s[j])
        );
    end

    assign bus.ready       = ready_r;
    assign bus.wr_conflict = wr_conflict_r;
    assign bus.rd_data     = rd_data_s;
    assign bus.rd_valid    = rd_valid_s;

endmodule

// File: tb/tb_mpram.sv
// Bench for mpram: two instances (write-first and read-first) share one stimulus
// and are compared every cycle against an array-level model of the memory.
module tb_mpram;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int NR     = 4;
    localparam int NW     = 2;
    localparam int DEPTH  = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mpram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NR(NR), .NW(NW)) bus1 ();
    mpram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NR(NR), .NW(NW)) bus0 ();

    assign bus0.clr     = bus1.clr;
    assign bus0.wr_en   = bus1.wr_en;
    assign bus0.wr_addr = bus1.wr_addr;
    assign bus0.wr_data = bus1.wr_data;
    assign bus0.rd_en   = bus1.rd_en;
    assign bus0.rd_addr = bus1.rd_addr;

    mpram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NR(NR), .NW(NW), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    mpram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NR(NR), .NW(NW), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave));

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole-array semantics, sweep treated as "blocked, then all zero".
    logic [31:0]   mem [DEPTH];
    int            clear_left;
    logic          m_ready;
    logic          m_conf;
    logic [NR-1:0] m_valid;
    logic [31:0]   m_data1 [NR];
    logic [31:0]   m_data0 [NR];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clear_left = DEPTH;
            m_ready = 1'b0;
            m_conf = 1'b0;
            m_valid = '0;
            for (int j = 0; j < NR; j++) begin
                m_data1[j] = 32'h0;
                m_data0[j] = 32'h0;
            end
        end else if (clear_left > 0) begin
            clear_left--;
            m_valid = '0;
            m_conf = 1'b0;
            if (clear_left == 0) begin
                for (int a = 0; a < DEPTH; a++) mem[a] = 32'h0;
                m_ready = 1'b1;
            end
        end else begin
            m_conf = 1'b0;
            for (int p = 0; p < NW; p++)
                for (int q = p + 1; q < NW; q++)
                    if (bus1.wr_en[p] && bus1.wr_en[q] &&
                        bus1.wr_addr[p*ADDR_W +: ADDR_W] == bus1.wr_addr[q*ADDR_W +: ADDR_W])
                        m_conf = 1'b1;
            for (int j = 0; j < NR; j++)
                if (bus1.rd_en[j]) m_data0[j] = mem[bus1.rd_addr[j*ADDR_W +: ADDR_W]];
            for (int p = 0; p < NW; p++)
                if (bus1.wr_en[p]) mem[bus1.wr_addr[p*ADDR_W +: ADDR_W]] = bus1.wr_data[p*DATA_W +: DATA_W];
            for (int j = 0; j < NR; j++)
                if (bus1.rd_en[j]) m_data1[j] = mem[bus1.rd_addr[j*ADDR_W +: ADDR_W]];
            m_valid = bus1.rd_en;
            if (bus1.clr) begin
                clear_left = DEPTH;
                m_ready = 1'b0;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        check("ready1", 32'(bus1.ready), 32'(m_ready));
        check("ready0", 32'(bus0.ready), 32'(m_ready));
        check("valid1", 32'(bus1.rd_valid), 32'(m_valid));
        check("valid0", 32'(bus0.rd_valid), 32'(m_valid));
        check("conflict1", 32'(bus1.wr_conflict), 32'(m_conf));
        check("conflict0", 32'(bus0.wr_conflict), 32'(m_conf));
        for (int j = 0; j < NR; j++) begin
            check("rdata1", bus1.rd_data[j*DATA_W +: DATA_W], m_data1[j]);
            check("rdata0", bus0.rd_data[j*DATA_W +: DATA_W], m_data0[j]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus1.clr = 1'b0;
        bus1.wr_en = '0;
        bus1.rd_en = '0;
    endtask

    task automatic set_wr(input int p, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        bus1.wr_en[p] = 1'b1;
        bus1.wr_addr[p*ADDR_W +: ADDR_W] = a;
        bus1.wr_data[p*DATA_W +: DATA_W] = d;
    endtask

    task automatic set_rd(input int j, input logic [ADDR_W-1:0] a);
        bus1.rd_en[j] = 1'b1;
        bus1.rd_addr[j*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!bus1.ready && n < 3000) begin
            bus1.wr_en = NW'($urandom);
            bus1.rd_en = NR'($urandom);
            step();
            n++;
            check({name, "_rdvalid"}, 32'(bus1.rd_valid), 32'h0);
        end
        idle();
        check(name, 32'(n), 32'd1024);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus1.wr_addr = '0;
        bus1.wr_data = '0;
        bus1.rd_addr = '0;
        idle();
        rst_n = 1'b0;
        repeat (3) step();
        check("reset_ready", 32'(bus1.ready), 32'h0);
        check("reset_rdata", bus1.rd_data[31:0], 32'h0);
        rst_n = 1'b1;
        wait_ready("reset_sweep_len");

        for (int j = 0; j < NR; j++) set_rd(j, 10'h3FF);
        step();
        idle();
        check("top_valid", 32'(bus1.rd_valid), 32'hF);
        for (int j = 0; j < NR; j++) check("top_zero", bus1.rd_data[j*DATA_W +: DATA_W], 32'h0);

        set_wr(0, 10'h005, 32'hDEADBEEF);
        step();
        idle();
        for (int j = 0; j < NR; j++) set_rd(j, 10'h005);
        step();
        idle();
        check("bcast_valid", 32'(bus1.rd_valid), 32'hF);
        for (int j = 0; j < NR; j++) check("bcast_data", bus1.rd_data[j*DATA_W +: DATA_W], 32'hDEADBEEF);

        set_wr(0, 10'h010, 32'h11111111);
        set_wr(1, 10'h010, 32'h22222222);
        step();
        idle();
        check("conflict_pulse", 32'(bus1.wr_conflict), 32'h1);
        set_rd(1, 10'h010);
        step();
        idle();
        check("conflict_clear", 32'(bus1.wr_conflict), 32'h0);
        check("conflict_win", bus1.rd_data[1*DATA_W +: DATA_W], 32'h22222222);

        set_wr(1, 10'h020, 32'hAAAA0000);
        step();
        idle();
        set_wr(0, 10'h020, 32'h0000BBBB);
        set_rd(3, 10'h020);
        step();
        idle();
        check("rdw_new", bus1.rd_data[3*DATA_W +: DATA_W], 32'h0000BBBB);
        check("rdw_old", bus0.rd_data[3*DATA_W +: DATA_W], 32'hAAAA0000);

        bus1.clr = 1'b1;
        set_wr(0, 10'h001, 32'h12345678);
        step();
        idle();
        check("clr_ready", 32'(bus1.ready), 32'h0);
        wait_ready("clr_sweep_len");
        set_rd(0, 10'h001);
        set_rd(2, 10'h005);
        step();
        idle();
        check("clr_addr1", bus1.rd_data[31:0], 32'h0);
        check("clr_addr5", bus1.rd_data[2*DATA_W +: DATA_W], 32'h0);

        bus1.clr = 1'b1;
        step();
        idle();
        repeat (500) step();
        rst_n = 1'b0;
        step();
        step();
        check("abort_ready", 32'(bus1.ready), 32'h0);
        rst_n = 1'b1;
        wait_ready("abort_sweep_len");

        for (int c = 0; c < 3000; c++) begin
            bus1.wr_en = NW'($urandom);
            bus1.rd_en = NR'($urandom);
            for (int p = 0; p < NW; p++) begin
                bus1.wr_addr[p*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 15));
                bus1.wr_data[p*DATA_W +: DATA_W] = $urandom;
            end
            for (int j = 0; j < NR; j++)
                bus1.rd_addr[j*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 15));
            step();
        end
        idle();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mpram.md
# mpram

Parametrised multi-port RAM: NW write ports and NR read ports over one logical 2^ADDR_W-word array, built from NR replicated storage banks so every read port sees every write. It is the general successor to the fixed four-read/two-write scratch memory in the datapath. It adds:
- registered reads with a valid strobe;
- deterministic same-address write arbitration;
- a selectable read-during-write mode;
- a hardware clear sequencer that zeroes the array after reset or on request.

## Interface

Parameters:
- DATA_W, 32, word width in bits
- ADDR_W, 10, address width; depth = 2^ADDR_W (1024)
- NR, 4, number of read ports (≥1)
- NW, 2, number of write ports (≥1)
- RDW_MODE, 1, same-cycle read/write to one address: 1 = new data (write-first), 0 = old data (read-first)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  request to zero the whole array; sampled only while ready=1
- ready  out  1  array usable; 0 while clearing
- wr_en  in  NW  per-port write enable
- wr_addr  in  NW*ADDR_W  write addresses, port i at bits [i*ADDR_W +: ADDR_W]
- wr_data  in  NW*DATA_W  write data, same packing
- rd_en  in  NR  per-port read enable
- rd_addr  in  NR*ADDR_W  read addresses
- rd_data  out  NR*DATA_W  registered read data
- rd_valid  out  NR  rd_data[j] updated this cycle
- wr_conflict  out  1  one-cycle pulse: two or more enabled writes hit one address in the previous cycle

## Operation

- FSM states are CLEAR and READY.
  - rst_n low forces CLEAR with sweep counter = 0, asynchronously.
  - CLEAR: each cycle writes 0 to address cnt in all banks and increments cnt. After writing address 2^ADDR_W−1, the next state is READY.
  - READY: if clr=1, the next state is CLEAR with cnt=0. Port accesses in the clr cycle itself still execute.
- In CLEAR, all wr_en are ignored (writes dropped) and all rd_en are ignored (rd_valid=0).
- Writes: every enabled write port writes all NR banks at the clock edge.
- Write arbitration: if several enabled ports share an address, the highest port index wins and the others are discarded. wr_conflict=1 on the next cycle.
- Reads: rd_en[j]=1 registers bank j at rd_addr[j] into rd_data[j] and sets rd_valid[j]=1.
  - When rd_valid[j]=0, rd_data[j] holds its previous value.
- Read-during-write to the same address in the same cycle:
  - RDW_MODE=1 returns the winning write data.
  - RDW_MODE=0 returns the pre-write contents.
- Multiple read ports reading one address is always legal.

## Timing

- Reset values: ready=0, rd_valid=0, rd_data=0, wr_conflict=0.
- Array contents are not reset directly; the sweep clears them.
- Clear duration: exactly 2^ADDR_W cycles.
  - ready rises on the first edge after the last sweep write, i.e. 1024 cycles after rst_n deasserts for ADDR_W=10.
- After clr=1 is sampled in READY, ready=0 from the next cycle for 2^ADDR_W cycles.
- Read latency is 1: rd_en at edge t gives rd_data/rd_valid valid after edge t+1.
- Write-to-read latency across ports:
  - A write at edge t is visible to any read issued at t+1.
  - It is also visible in the same cycle if RDW_MODE=1.
- rst_n asserted mid-sweep or mid-operation aborts everything. The sweep restarts from address 0 on deassertion.
- wr_conflict is registered, one cycle after the conflicting writes.

## Structure

- Shared package holds:
  - FSM state encoding (ST_CLEAR, ST_READY);
  - default width/depth constants (32, 10, 1024).
- One sub-module, mpram_bank: a single copy of the array with NW write ports, one registered read port, and the RDW_MODE forwarding mux. Instantiated NR times via generate.
- The top level contains:
  - the FSM and sweep counter;
  - the write-enable masking during CLEAR;
  - the same-address arbitration (priority mask per port, shared by all banks);
  - the wr_conflict flag.

## Test plan

- Reset, then rst_n high → ready=0 for exactly 1024 cycles, then 1. A read of address 0x3FF on every port returns 0 with rd_valid=1 one cycle later.
- Port 0 writes 0xDEADBEEF to 0x005, then all 4 read ports read 0x005 → every rd_data=0xDEADBEEF, rd_valid=4'b1111 after 1 cycle.
- Ports 0 and 1 write 0x11111111 and 0x22222222 to 0x010 in the same cycle → wr_conflict=1 for one cycle. A read of 0x010 returns 0x22222222.
- Address 0x020 holds 0xAAAA0000; a write of 0x0000BBBB and a read of 0x020 occur in the same cycle:
  - RDW_MODE=1 returns 0x0000BBBB;
  - RDW_MODE=0 returns 0xAAAA0000.
- In READY, clr=1 together with a write of 0x12345678 to 0x001 → ready=0 for 1024 cycles. Writes and reads during CLEAR are ignored (rd_valid=0). Afterwards, address 0x001 reads 0.
- rst_n pulsed low at sweep count 500 → ready stays 0. A full 1024-cycle sweep restarts from address 0.
